adc_sample_pacer: RTL



---
 rtl/adc_sample_pacer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/adc_sample_pacer.sv
// adc_sample_pacer
//   Paces samples out of the show-ahead ADC sample FIFO at one sample every
//   TICK_DIV system clocks and converts each word from offset binary to
//   two's complement. The one-cycle sample strobe drives the filter-bank
//   enables. A sample period that finds the FIFO empty is an underrun: it is
//   flagged with a pulse and counted in a saturating counter.
//
// Ports
//   i_clk          system clock
//   i_reset        asynchronous active-low reset
//   i_enable       level; 1 = pacing active, 0 = idle
//   i_clr_cnt      synchronous clear of o_underrun_cnt (wins over increment)
//   i_fifo_data    FIFO show-ahead word, valid while i_fifo_empty = 0
//   i_fifo_empty   FIFO read-side empty flag
//   o_fifo_rdreq   one-cycle read acknowledge for the consumed word
//   o_sample_data  converted signed sample, held between strobes
//   o_sample_valid one-cycle sample strobe
//   o_underrun     one-cycle pulse on a sample period with no data
//   o_underrun_cnt saturating underrun count
//   o_running      high while the pacer is in RUN
module adc_sample_pacer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned TICK_DIV   = 100,
    parameter int unsigned OFFSET     = 2048,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_clr_cnt,
    input  logic [DATA_WIDTH-1:0]        i_fifo_data,
    input  logic                         i_fifo_empty,
    output logic                         o_fifo_rdreq,
    output logic signed [DATA_WIDTH-1:0] o_sample_data,
    output logic                         o_sample_valid,
    output logic                         o_underrun,
    output logic [CNT_WIDTH-1:0]         o_underrun_cnt,
    output logic                         o_running
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]         TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DATA_WIDTH-1:0] OFFSET_W  = DATA_WIDTH'(OFFSET);

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t                  state, state_next;
    logic [TW-1:0]           tick_cnt, tick_next;
    logic                    rdreq_next, valid_next, underrun_next;
    logic [DATA_WIDTH-1:0]   data_next;
    logic [CNT_WIDTH-1:0]    cnt_next;
    logic                    tick;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= IDLE;
            tick_cnt       <= '0;
            o_fifo_rdreq   <= 1'b0;
            o_sample_data  <= '0;
            o_sample_valid <= 1'b0;
            o_underrun     <= 1'b0;
            o_underrun_cnt <= '0;
        end else begin
            state          <= state_next;
            tick_cnt       <= tick_next;
            o_fifo_rdreq   <= rdreq_next;
            o_sample_data  <= data_next;
            o_sample_valid <= valid_next;
            o_underrun     <= underrun_next;
            o_underrun_cnt <= cnt_next;
        end
    end

    assign tick      = (state == RUN) && (tick_cnt == TICK_LAST);
    assign o_running = (state == RUN);

    always_comb begin
        state_next    = state;
        tick_next     = tick_cnt;
        rdreq_next    = 1'b0;
        valid_next    = 1'b0;
        underrun_next = 1'b0;
        data_next     = o_sample_data;
        cnt_next      = o_underrun_cnt;

        case (state)
            IDLE: begin
                tick_next = '0;
                if (i_enable) state_next = PRIME;
            end
            PRIME: begin
                tick_next = '0;
                if (!i_fifo_empty) state_next = RUN;
            end
            RUN: begin
                tick_next = tick ? '0 : tick_cnt + 1'b1;
                if (tick) begin
                    if (!i_fifo_empty) begin
                        // Offset binary to two's complement: wrap-around subtract.
                        data_next  = i_fifo_data - OFFSET_W;
                        valid_next = 1'b1;
                        rdreq_next = 1'b1;
                    end else begin
                        underrun_next = 1'b1;
                        if (o_underrun_cnt != '1) cnt_next = o_underrun_cnt + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Dropping enable overrides whatever the tick would have registered.
        if (!i_enable) begin
            state_next    = IDLE;
            tick_next     = '0;
            rdreq_next    = 1'b0;
            valid_next    = 1'b0;
            underrun_next = 1'b0;
            data_next     = o_sample_data;
            cnt_next      = o_underrun_cnt;
        end

        if (i_clr_cnt) cnt_next = '0;
    end

endmodule
